// File: rtl/fifo_pkg.sv
// Shared definitions for the stream FIFO: fill-counter width helper and
// default almost-full / almost-empty thresholds.
package fifo_pkg;

  localparam int DEF_AE_THRESH = 1;
  localparam int DEF_AF_MARGIN = 2;

  // The fill counter must represent 0..DEPTH inclusive, so it needs one extra bit.
  function automatic int fill_width(input int lgflen);
    return lgflen + 1;
  endfunction

  // Default almost-full point sits DEF_AF_MARGIN words below capacity,
  // clamped so tiny FIFOs still get a legal threshold.
  function automatic int def_af_thresh(input int lgflen);
    int depth;
    depth = 1 << lgflen;
    return (depth > DEF_AF_MARGIN) ? depth - DEF_AF_MARGIN : depth;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x W storage with one synchronous write port and one registered read port.
// The read register forwards same-cycle write data when both ports hit one address.
module fifo_mem #(
  parameter int W  = 16,
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Only the read register is reset; array contents are don't-care until written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
    end
  end

endmodule

// File: rtl/stream_fifo.sv
// Valid/ready stream FIFO with registered head-of-queue output, fill count and
// registered almost-full / almost-empty flags.
//
// Handshake: a transfer happens on a side exactly when valid && ready are both
// high at a rising clk edge; valid never waits on ready, and s_ready / m_valid /
// m_data are pure register outputs with no combinational path from any input.
module stream_fifo
  import fifo_pkg::*;
#(
  parameter int W         = 16,
  parameter int LGFLEN    = 7,
  parameter int AF_THRESH = def_af_thresh(LGFLEN),
  parameter int AE_THRESH = DEF_AE_THRESH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic [W-1:0]                  s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic [W-1:0]                  m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [fill_width(LGFLEN)-1:0] fill,
  output logic                          almost_full,
  output logic                          almost_empty
);

  localparam int DEPTH = 2 ** LGFLEN;
  localparam int FW    = fill_width(LGFLEN);

  localparam logic [FW-1:0]     DEPTH_F  = FW'(DEPTH);
  localparam logic [FW-1:0]     AF_F     = FW'(AF_THRESH);
  localparam logic [FW-1:0]     AE_F     = FW'(AE_THRESH);
  localparam logic [FW-1:0]     FILL_ONE = FW'(1);
  localparam logic [LGFLEN-1:0] PTR_ONE  = LGFLEN'(1);

  if (W < 1) begin : g_bad_w
    $error("stream_fifo: W must be >= 1");
  end
  if (LGFLEN < 1) begin : g_bad_lgflen
    $error("stream_fifo: LGFLEN must be >= 1");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("stream_fifo: AF_THRESH must be within 1..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $error("stream_fifo: AE_THRESH must be within 0..DEPTH-1");
  end

  logic [LGFLEN-1:0] wr_ptr;
  logic [LGFLEN-1:0] rd_ptr;
  logic [LGFLEN-1:0] rd_ptr_next;
  logic [FW-1:0]     fill_next;
  logic              do_write;
  logic              do_read;
  logic              mem_wr_en;
  logic              mem_rd_en;

  always_comb begin
    do_write    = s_valid && s_ready;
    do_read     = m_valid && m_ready;
    rd_ptr_next = do_read ? rd_ptr + PTR_ONE : rd_ptr;
    fill_next   = fill;
    if (flush) begin
      fill_next = '0;
    end else if (do_write && !do_read) begin
      fill_next = fill + FILL_ONE;
    end else if (!do_write && do_read) begin
      fill_next = fill - FILL_ONE;
    end
  end

  // The read register always fetches the word that will be at the head after
  // this edge; if that word is being written right now, the memory forwards it.
  assign mem_wr_en = do_write && !flush;
  assign mem_rd_en = !flush && (fill_next != '0);

  fifo_mem #(
    .W  (W),
    .AW (LGFLEN)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (mem_wr_en),
    .wr_addr (wr_ptr),
    .wr_data (s_data),
    .rd_en   (mem_rd_en),
    .rd_addr (rd_ptr_next),
    .rd_data (m_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_write) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      rd_ptr <= rd_ptr_next;
    end
  end

  // Status outputs are registered from fill_next so they always agree with fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill         <= '0;
      m_valid      <= 1'b0;
      s_ready      <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      fill         <= fill_next;
      m_valid      <= (fill_next != '0);
      s_ready      <= (fill_next < DEPTH_F);
      almost_full  <= (fill_next >= AF_F);
      almost_empty <= (fill_next <= AE_F);
    end
  end

endmodule

// File: tb/tb_stream_fifo.sv
// Self-checking bench for stream_fifo: directed scenarios plus random traffic,
// all outputs compared every cycle against a queue-based reference model.
module tb_stream_fifo;

  localparam int W      = 16;
  localparam int LGFLEN = 3;
  localparam int DEPTH  = 8;
  localparam int AF     = 6;
  localparam int AE     = 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           flush = 1'b0;
  logic [W-1:0]   s_data = '0;
  logic           s_valid = 1'b0;
  logic           s_ready;
  logic [W-1:0]   m_data;
  logic           m_valid;
  logic           m_ready = 1'b0;
  logic [LGFLEN:0] fill;
  logic           almost_full;
  logic           almost_empty;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];

  stream_fifo #(
    .W         (W),
    .LGFLEN    (LGFLEN),
    .AF_THRESH (AF),
    .AE_THRESH (AE)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .fill         (fill),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Every observable output is a pure function of the queued words.
  task automatic check_outputs(input string tag);
    int n;
    n = exp_q.size();
    check_eq({tag, ".fill"},         32'(fill),         n);
    check_eq({tag, ".m_valid"},      32'(m_valid),      32'(n > 0));
    check_eq({tag, ".s_ready"},      32'(s_ready),      32'(n < DEPTH));
    check_eq({tag, ".almost_full"},  32'(almost_full),  32'(n >= AF));
    check_eq({tag, ".almost_empty"}, 32'(almost_empty), 32'(n <= AE));
    if (n > 0) begin
      check_eq({tag, ".m_data"}, 32'(m_data), 32'(exp_q[0]));
    end
  endtask

  // driver: apply inputs after the falling edge, advance one clock, update model
  task automatic step(input logic sv, input logic [W-1:0] sd, input logic mr, input logic fl);
    bit wr;
    bit rd;
    s_valid = sv;
    s_data  = sd;
    m_ready = mr;
    flush   = fl;
    #1;
    check_outputs("pre");
    wr = sv && (exp_q.size() < DEPTH);
    rd = mr && (exp_q.size() > 0);
    @(posedge clk);
    if (fl) begin
      exp_q.delete();
    end else begin
      if (rd) void'(exp_q.pop_front());
      if (wr) exp_q.push_back(sd);
    end
    @(negedge clk);
    check_outputs("post");
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) step(1'b0, '0, 1'b1, 1'b0);
  endtask

  int wp[3] = '{80, 30, 60};
  int rp[3] = '{30, 80, 60};

  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst.fill",         32'(fill),         0);
    check_eq("rst.m_valid",      32'(m_valid),      0);
    check_eq("rst.s_ready",      32'(s_ready),      1);
    check_eq("rst.almost_full",  32'(almost_full),  0);
    check_eq("rst.almost_empty", 32'(almost_empty), 1);
    check_eq("rst.m_data",       32'(m_data),       0);
    rst_n = 1'b1;

    // single write into empty FIFO, accepted on the first edge after reset
    step(1'b1, 16'h0001, 1'b0, 1'b0);
    check_eq("first.m_data", 32'(m_data), 32'h0001);
    check_eq("first.fill",   32'(fill),   1);
    step(1'b0, '0, 1'b0, 1'b1);

    // fill to capacity, then hold a 9th word
    for (int i = 0; i < DEPTH; i++) step(1'b1, W'(16'h0010 + i), 1'b0, 1'b0);
    check_eq("full.s_ready", 32'(s_ready), 0);
    step(1'b1, 16'h0018, 1'b0, 1'b0);
    check_eq("full.hold_fill", 32'(fill), 8);
    // read while full: no write-through, write lands next cycle
    step(1'b1, 16'h0018, 1'b1, 1'b0);
    check_eq("full_rd.fill",   32'(fill),   7);
    check_eq("full_rd.m_data", 32'(m_data), 32'h0011);
    step(1'b1, 16'h0018, 1'b0, 1'b0);
    check_eq("full_rd.refill", 32'(fill), 8);
    drain();

    // streaming: 40 words with both sides always active
    for (int i = 0; i < 40; i++) step(1'b1, W'(16'h0100 + i), 1'b1, 1'b0);
    drain();

    // flush with concurrent write and read
    for (int i = 0; i < 5; i++) step(1'b1, W'(16'h0200 + i), 1'b0, 1'b0);
    step(1'b1, 16'h0205, 1'b1, 1'b1);
    check_eq("flush.fill",    32'(fill),    0);
    check_eq("flush.m_valid", 32'(m_valid), 0);
    check_eq("flush.s_ready", 32'(s_ready), 1);
    step(1'b0, '0, 1'b1, 1'b0);

    // asynchronous reset in the middle of a cycle
    for (int i = 0; i < 3; i++) step(1'b1, W'(16'h0300 + i), 1'b0, 1'b0);
    s_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    check_eq("async_rst.m_valid", 32'(m_valid), 0);
    check_eq("async_rst.fill",    32'(fill),    0);
    check_eq("async_rst.s_ready", 32'(s_ready), 1);
    check_eq("async_rst.m_data",  32'(m_data),  0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 16'hBEEF, 1'b0, 1'b0);
    check_eq("after_rst.m_data", 32'(m_data), 32'hBEEF);
    drain();

    // random traffic in write-heavy, read-heavy and balanced phases
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 150; i++) begin
        step(1'($urandom_range(99) < wp[p]), W'($urandom),
             1'($urandom_range(99) < rp[p]), 1'($urandom_range(63) == 0));
      end
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
